bpm_step_timer: RTL
===================

// Module: bpm_step_timer
// PURPOSE
//  Parametrised successor to the single-rate BPM step generator. Converts a tempo
//  (BPM) into step pulses at SUBDIV steps per beat and tracks a wrapping step index
//  over STEPS steps. Adds swing, glitch-free tempo changes and a multi-cycle divider.
//  Sits between the front-panel tempo controls and the step sequencer core.
// PARAMETERS
//  CLK_HZ  50_000_000  system clock frequency in Hz
//  BPM_W   10          BPM input width
//  SUBDIV  4           steps per beat (4 = 16th notes)
//  STEPS   16          sequence length; StepIdx wraps at STEPS-1
//  DIV_W   32          divider/period width; CLK_HZ*60 must fit in DIV_W bits
// PORTS
//  Clock     in   1               system clock, rising edge
//  Reset     in   1               synchronous, active-high
//  Start     in   1               1-cycle pulse: (re)start from step 0
//  Stop      in   1               1-cycle pulse: stop, return to idle
//  BPM       in   BPM_W           tempo in beats/min; 0 = halt
//  Swing     in   6               swing amount, offset = (period*Swing)>>7
//  Step      out  1               1-cycle pulse per step
//  StepIdx   out  $clog2(STEPS)   index of the step just pulsed
//  Beat      out  1               1-cycle pulse, coincident with Step when StepIdx%SUBDIV==0
//  Running   out  1               high in CALC or RUN
//  Busy      out  1               divider in progress
// BEHAVIOUR
//  - Reset (sync, wins over all inputs): state=IDLE; Step=Beat=Running=Busy=0; StepIdx=0;
//    counter, period and latched BPM cleared.
//  - Period P = (CLK_HZ*60) / (BPM*SUBDIV), integer truncation. If the quotient is <2,
//    P is clamped to 2. Computed by a restoring divider: exactly DIV_W cycles, Busy high
//    throughout.
//  - States:
//     IDLE: outputs 0. Start with BPM!=0 -> latch BPM, go to CALC. Start with BPM==0 -> ignored.
//     CALC: divider runs. On done -> RUN, with Step=Beat=1 and StepIdx=0 in the first RUN
//           cycle. The first Step is exactly DIV_W+1 cycles after the Start cycle.
//     RUN:  cycle counter Q counts from 0. A step fires when Q==I-1; Q then returns to 0.
//           Interval I depends on the index of the step that just fired:
//             even index -> I = P+S;  odd index -> I = P-S;  where S=(P*Swing)>>7.
//           S<P/2 always holds, so I>=1. Average pair interval is 2P.
//           StepIdx increments on each Step and wraps STEPS-1 -> 0.
//  - Tempo change in RUN: BPM != latched -> latch the new BPM and start a background divide.
//    Steps keep using the old P. The new P is adopted at the first step boundary after the
//    divide completes; Q is never truncated mid-interval.
//    A BPM change while Busy restarts the divide with the newest value.
//    Swing is sampled at each step boundary.
//  - BPM==0 in RUN or CALC -> IDLE, no further Step; StepIdx cleared.
//  - Stop in any state -> IDLE next cycle, StepIdx=0. Stop wins over a simultaneous Start.
//  - Start in CALC or RUN -> restart: latch BPM, go to CALC, StepIdx=0. No Step until the
//    new divide completes.
//  - Outputs are registered. Step and Beat are never high for 2 consecutive cycles unless
//    I==1 (not reachable with P>=2 and S<P/2).
// TESTING  (CLK_HZ=6000, SUBDIV=4, STEPS=16, DIV_W=32 unless noted)
//  1. Reset, BPM=60, Swing=0, Start -> first Step at +33 cycles, StepIdx=0, Beat=1;
//     subsequent Steps every 1500 cycles; Beat on idx 0,4,8,12; idx 15 -> 0 wrap.
//  2. BPM=60, Swing=32 -> S=375: idx0->idx1 gap 1875, idx1->idx2 gap 1125, repeating.
//  3. Running at BPM=60, change to 120 mid-interval -> current interval still 1500;
//     intervals become 750 from the first boundary >=32 cycles after the change.
//  4. Stop and Start in the same cycle while running -> IDLE, no Step, StepIdx=0.
//     BPM=0 in RUN -> IDLE. Start with BPM=0 -> stays IDLE.
//  5. Reset asserted mid-CALC and mid-RUN -> all outputs 0 next cycle; Start afterwards
//     behaves as in test 1.
//  6. BPM=1023, CLK_HZ=1000 -> quotient 14; the period clamp test uses CLK_HZ=100 ->
//     P=2, Step every 2 cycles.

Source files
------------

// File: rtl/bpm_step_timer.sv
// rtl/bpm_step_timer.sv - tempo to step-pulse timer with swing, background divider and wrapping step index
module bpm_step_timer #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BPM_W  = 10,
  parameter int SUBDIV = 4,
  parameter int STEPS  = 16,
  parameter int DIV_W  = 32
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic                     Stop,
  input  logic [BPM_W-1:0]         BPM,
  input  logic [5:0]               Swing,
  output logic                     Step,
  output logic [$clog2(STEPS)-1:0] StepIdx,
  output logic                     Beat,
  output logic                     Running,
  output logic                     Busy
);

  localparam int IDX_W = $clog2(STEPS);
  localparam int DC_W  = $clog2(DIV_W);
  localparam logic [63:0]      DIVIDEND_64 = 64'(CLK_HZ) * 64'd60;
  localparam logic [DIV_W-1:0] DIVIDEND    = DIVIDEND_64[DIV_W-1:0];

  typedef enum logic [1:0] {IDLE, CALC, RUN} state_t;

  state_t             state_q, state_d;
  logic               step_q, step_d;
  logic               beat_q, beat_d;
  logic               running_q, running_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   period_q, period_d;
  logic [DIV_W-1:0]   intv_q, intv_d;
  logic [DIV_W-1:0]   pnew_q, pnew_d;
  logic               pend_q, pend_d;
  logic [BPM_W-1:0]   bpm_q, bpm_d;
  logic [DIV_W:0]     rem_q, rem_d;
  logic [DIV_W-1:0]   quo_q, quo_d;
  logic [DC_W-1:0]    dcnt_q, dcnt_d;
  logic               drun_q, drun_d;

  logic [DIV_W-1:0]   divisor;
  logic [DIV_W:0]     rem_sh, rem_nx;
  logic [DIV_W-1:0]   quo_nx, q_fin;
  logic               div_ge, div_last;
  logic [IDX_W-1:0]   idx_inc;
  logic               beat_nx, fire;
  logic [DIV_W-1:0]   p_eff, p_sel, swing_off, ival;
  logic               sel_odd;
  logic [DIV_W+5:0]   swing_prod;
  logic               do_load, do_idle;

  // One restoring-divider iteration per cycle; the quotient shifts in from the LSB.
  always_comb begin
    divisor  = DIV_W'(bpm_q) * DIV_W'(SUBDIV);
    rem_sh   = {rem_q[DIV_W-1:0], quo_q[DIV_W-1]};
    div_ge   = (rem_sh >= {1'b0, divisor});
    rem_nx   = div_ge ? (rem_sh - {1'b0, divisor}) : rem_sh;
    quo_nx   = {quo_q[DIV_W-2:0], div_ge};
    div_last = (dcnt_q == DC_W'(DIV_W - 1));
    q_fin    = (quo_nx < DIV_W'(2)) ? DIV_W'(2) : quo_nx;
  end

  // Interval following the step about to fire: even index is long, odd is short.
  always_comb begin
    idx_inc    = (idx_q == IDX_W'(STEPS - 1)) ? '0 : idx_q + IDX_W'(1);
    beat_nx    = ((int'(idx_inc) % SUBDIV) == 0);
    fire       = (cnt_q == intv_q - DIV_W'(1));
    p_eff      = pend_q ? pnew_q : period_q;
    p_sel      = (state_q == CALC) ? q_fin : p_eff;
    sel_odd    = (state_q == CALC) ? 1'b0 : idx_inc[0];
    swing_prod = (DIV_W+6)'(p_sel) * (DIV_W+6)'(Swing);
    swing_off  = DIV_W'(swing_prod >> 7);
    ival       = sel_odd ? (p_sel - swing_off) : (p_sel + swing_off);
  end

  always_comb begin
    state_d  = state_q;
    step_d   = 1'b0;
    beat_d   = 1'b0;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    intv_d   = intv_q;
    pnew_d   = pnew_q;
    pend_d   = pend_q;
    bpm_d    = bpm_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dcnt_d   = dcnt_q;
    drun_d   = drun_q;
    do_load  = 1'b0;
    do_idle  = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start && !Stop && (BPM != '0)) begin
          do_load = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (Stop || (BPM == '0)) begin
          do_idle = 1'b1;
        end else if (Start || (BPM != bpm_q)) begin
          do_load = 1'b1;
        end else begin
          rem_d  = rem_nx;
          quo_d  = quo_nx;
          dcnt_d = dcnt_q + DC_W'(1);
          if (div_last) begin
            drun_d   = 1'b0;
            period_d = q_fin;
            intv_d   = ival;
            state_d  = RUN;
            step_d   = 1'b1;
            beat_d   = 1'b1;
            idx_d    = '0;
            cnt_d    = '0;
          end
        end
      end
      RUN: begin
        if (Stop || (BPM == '0)) begin
          do_idle = 1'b1;
        end else if (Start) begin
          do_load = 1'b1;
          state_d = CALC;
        end else begin
          if (fire) begin
            step_d = 1'b1;
            beat_d = beat_nx;
            idx_d  = idx_inc;
            cnt_d  = '0;
            intv_d = ival;
            if (pend_q) begin
              period_d = pnew_q;
              pend_d   = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
          // New tempo is divided in the background and only takes effect at a later boundary.
          if (BPM != bpm_q) begin
            do_load = 1'b1;
          end else if (drun_q) begin
            rem_d  = rem_nx;
            quo_d  = quo_nx;
            dcnt_d = dcnt_q + DC_W'(1);
            if (div_last) begin
              drun_d = 1'b0;
              pend_d = 1'b1;
              pnew_d = q_fin;
            end
          end
        end
      end
      default: do_idle = 1'b1;
    endcase

    if (do_idle) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      drun_d  = 1'b0;
      pend_d  = 1'b0;
    end

    if (do_load) begin
      bpm_d  = BPM;
      rem_d  = '0;
      quo_d  = DIVIDEND;
      dcnt_d = '0;
      drun_d = 1'b1;
      pend_d = 1'b0;
      if (state_d == CALC) begin
        idx_d = '0;
        cnt_d = '0;
      end
    end

    running_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      step_q    <= 1'b0;
      beat_q    <= 1'b0;
      running_q <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      period_q  <= '0;
      intv_q    <= '0;
      pnew_q    <= '0;
      pend_q    <= 1'b0;
      bpm_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dcnt_q    <= '0;
      drun_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      beat_q    <= beat_d;
      running_q <= running_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      intv_q    <= intv_d;
      pnew_q    <= pnew_d;
      pend_q    <= pend_d;
      bpm_q     <= bpm_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dcnt_q    <= dcnt_d;
      drun_q    <= drun_d;
    end
  end

  assign Step    = step_q;
  assign Beat    = beat_q;
  assign StepIdx = idx_q;
  assign Running = running_q;
  assign Busy    = drun_q;

endmodule
